lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit directly downstream of the ALU: takes the ALU result as the effective address plus rs2 store data and runs a req/gnt/rvalid transaction on the data-memory port.
- Handles byte/half/word sizing, byte enables, store-data lane replication, load extraction with sign/zero extension and misalignment detection.
- Stalls the core via a valid/done handshake until the access completes.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 64, bus-timeout limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_valid  in  1  core requests an access; held with operands stable until lsu_done.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH, 010 SW (stores).
- lsu_addr  in  XLEN  effective address (ALU result).
- lsu_wdata  in  XLEN  store data (rs2).
- lsu_done  out  1  one-cycle completion pulse.
- lsu_err  out  1  valid with lsu_done: misaligned access, illegal funct3 or timeout.
- lsu_rdata  out  XLEN  extended load result; valid with lsu_done.
- lsu_stall  out  1  lsu_valid & ~lsu_done (combinational).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  XLEN  word-aligned address, lsu_addr with bits [1:0] forced to 00.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read word.

Behaviour:
- Reset: state IDLE; lsu_done, lsu_err, mem_req and mem_we = 0; mem_be = 0; mem_addr, mem_wdata and lsu_rdata = 0. An assertion mid-transaction aborts immediately: mem_req drops asynchronously and outstanding rvalid is not awaited.
- All mem_* outputs are registered. States: IDLE, REQ, WAIT, DONE.
- IDLE, lsu_valid=1:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal funct3: go to DONE with err=1, no memory request.
  - Otherwise: capture addr, be, wdata, we, funct3 and offset; go to REQ.
- REQ: mem_req=1; addr, be, we and wdata held stable until mem_gnt.
  - On gnt, store: go to DONE.
  - On gnt, load: go to WAIT. mem_req drops the cycle after gnt.
- WAIT: on mem_rvalid, register the extracted load data; go to DONE. rvalid is never sampled in REQ; the earliest is the cycle after gnt.
- DONE: lsu_done=1 for exactly one cycle, then IDLE. Core deasserts or changes lsu_valid the cycle after done. IDLE ignores lsu_valid during the DONE cycle.
- Byte enables:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << addr[1:0].
  - SW: 1111.
  - Loads: same pattern.
- Store data: SB replicates the byte 4x; SH replicates the half 2x; SW is passed as is.
- Load extraction uses the byte offset. LB/LH sign-extend; LBU/LHU zero-extend.
- Minimum latency (valid at cycle 0): req at cycle 1; gnt at cycle 1 gives store done at cycle 2; load rvalid at cycle 2 gives done at cycle 3.
- Misaligned access: done at cycle 1.
- lsu_rdata holds its value until the next load completes. Stores leave it unchanged.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ/WAIT and increments each cycle spent in them.
  - When it reaches TIMEOUT_CYCLES-1 without gnt/rvalid: go to DONE with err=1; mem_req drops.
  - A late rvalid arriving in IDLE is ignored.
- Undefined: no counter; the unit waits indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - State enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One sub-module, lsu_load_align: combinational; inputs rdata, offset and funct3; output is the extended result. It is reused by the future cache path.

Test Plan:
- SW addr 0x1000, data 0xDEADBEEF, gnt on the first req cycle -> mem_be=1111, mem_addr=0x1000, mem_wdata=0xDEADBEEF, done at cycle 2, err=0.
- SB addr 0x1003, data 0x000000A5 -> mem_be=1000, mem_addr=0x1000, mem_wdata=0xA5A5A5A5.
- LB addr 0x2002, rdata 0x12F45678, gnt delayed 3 cycles, rvalid 2 cycles later -> rdata=0xFFFFFFF4; repeated as LBU -> 0x000000F4; req held stable throughout.
- LH addr 0x2001 and LW addr 0x2002 -> done at cycle 1 with err=1, mem_req never asserted.
- Reset asserted while in WAIT -> mem_req=0 and state IDLE immediately; a following LW completes normally.
- LSU_TIMEOUT_EN, gnt never asserted -> done with err=1 exactly TIMEOUT_CYCLES cycles after entering REQ.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes,
// byte-enable generation and access legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   byte_enable = 4'b0001 << offset;
            2'b01:   byte_enable = 4'b0011 << offset;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    // Stores only have signed-size encodings; loads additionally allow BU/HU.
    function automatic logic access_ok(input logic we, input logic [2:0] funct3, input logic [1:0] offset);
        logic legal;
        logic aligned;
        if (we)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~offset[0];
            default: aligned = (offset == 2'b00);
        endcase
        access_ok = legal & aligned;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory port of the load/store unit: req/gnt request phase plus rvalid read return.
interface lsu_mem_ctrl_if #(parameter int XLEN = 32);

    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                    input  mem_gnt, mem_rvalid, mem_rdata);

    modport slave  (input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                    output mem_gnt, mem_rvalid, mem_rdata);

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shifts the read word by the byte offset and
// sign- or zero-extends according to funct3. Shared with the cache path.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (funct3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a req/gnt/rvalid data-memory port and stalling the core until done.
// Define LSU_TIMEOUT_EN to abort with an error after TIMEOUT_CYCLES without gnt/rvalid.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lsu_valid,
    input  logic             lsu_we,
    input  logic [2:0]       lsu_funct3,
    input  logic [XLEN-1:0]  lsu_addr,
    input  logic [XLEN-1:0]  lsu_wdata,
    output logic             lsu_done,
    output logic             lsu_err,
    output logic [XLEN-1:0]  lsu_rdata,
    output logic             lsu_stall,
    lsu_mem_ctrl_if.master   mem
);

    lsu_state_t      state, next_state;
    logic            capture, err_set, load_done, req_end, timeout;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;
    logic [XLEN-1:0] store_data, load_result;

    assign lsu_done  = (state == DONE);
    assign lsu_stall = lsu_valid & ~lsu_done;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt;

    // Restarts on every state change so REQ and WAIT each get a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (next_state != state)
            wait_cnt <= '0;
        else if (state == REQ || state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == REQ || state == WAIT) &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        case (lsu_funct3[1:0])
            2'b00:   store_data = {(XLEN/8){lsu_wdata[7:0]}};
            2'b01:   store_data = {(XLEN/16){lsu_wdata[15:0]}};
            default: store_data = lsu_wdata;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (mem.mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        err_set    = 1'b0;
        load_done  = 1'b0;
        req_end    = 1'b0;
        case (state)
            IDLE: begin
                if (lsu_valid) begin
                    if (!access_ok(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
                        next_state = DONE;
                        err_set    = 1'b1;
                    end else begin
                        next_state = REQ;
                        capture    = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    next_state = we_q ? DONE : WAIT;
                    req_end    = 1'b1;
                end else if (timeout) begin
                    next_state = DONE;
                    err_set    = 1'b1;
                    req_end    = 1'b1;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    next_state = DONE;
                    load_done  = 1'b1;
                end else if (timeout) begin
                    next_state = DONE;
                    err_set    = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'b0000;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            lsu_err       <= 1'b0;
            lsu_rdata     <= '0;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
        end else begin
            lsu_err <= err_set;
            if (capture) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= lsu_we;
                mem.mem_be    <= byte_enable(lsu_funct3, lsu_addr[1:0]);
                mem.mem_addr  <= {lsu_addr[XLEN-1:2], 2'b00};
                mem.mem_wdata <= store_data;
                we_q          <= lsu_we;
                funct3_q      <= lsu_funct3;
                offset_q      <= lsu_addr[1:0];
            end else if (req_end) begin
                mem.mem_req <= 1'b0;
                mem.mem_we  <= 1'b0;
            end
            if (load_done)
                lsu_rdata <= load_result;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-level reference model.
// The timeout scenario is compiled in only when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;
    localparam int BUDGET  = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lsu_valid = 1'b0;
    logic             lsu_we = 1'b0;
    logic [2:0]       lsu_funct3 = 3'b000;
    logic [XLEN-1:0]  lsu_addr = '0;
    logic [XLEN-1:0]  lsu_wdata = '0;
    logic             lsu_done, lsu_err, lsu_stall;
    logic [XLEN-1:0]  lsu_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rdata = 32'h0;

    lsu_mem_ctrl_if #(.XLEN(XLEN)) mem_bus ();

    lsu_mem_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lsu_valid  (lsu_valid),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_done   (lsu_done),
        .lsu_err    (lsu_err),
        .lsu_rdata  (lsu_rdata),
        .lsu_stall  (lsu_stall),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes, legality, and expected bus/result values.
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return legal && ((addr % size_bytes(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int mask;
        mask = ((1 << size_bytes(f3)) - 1) << (addr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = wdata[8*(k % size_bytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        longint v;
        longint span;
        span = longint'(1) << (8 * size_bytes(f3));
        v = (longint'(word) >> (8 * (addr % 4))) % span;
        if (f3[2] == 1'b0 && v >= span / 2)
            v = v - span;
        return v[31:0];
    endfunction

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                                 input logic [31:0] rword,
                                 output int done_cyc, output logic err, output logic [31:0] rdata,
                                 output logic req_seen, output logic req_bad, output logic [3:0] be_o,
                                 output logic [31:0] addr_o, output logic [31:0] wdata_o,
                                 output logic we_o, output logic extra_bad);
        int cyc, req_cnt, gnt_cyc;
        logic granted;
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
        cyc = 0; req_cnt = 0; gnt_cyc = -1; granted = 1'b0;
        done_cyc = -1; err = 1'b0; rdata = '0; req_seen = 1'b0; req_bad = 1'b0;
        be_o = '0; addr_o = '0; wdata_o = '0; we_o = 1'b0; extra_bad = 1'b0;
        while (done_cyc < 0 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = $urandom;
            if (lsu_stall !== ~lsu_done) extra_bad = 1'b1;
            if (lsu_done === 1'b1) begin
                done_cyc = cyc; err = lsu_err; rdata = lsu_rdata;
            end else if (mem_bus.mem_req === 1'b1) begin
                if (granted) req_bad = 1'b1;
                if (!req_seen) begin
                    req_seen = 1'b1; be_o = mem_bus.mem_be; addr_o = mem_bus.mem_addr;
                    wdata_o = mem_bus.mem_wdata; we_o = mem_bus.mem_we;
                end else if (mem_bus.mem_be !== be_o || mem_bus.mem_addr !== addr_o ||
                             mem_bus.mem_wdata !== wdata_o || mem_bus.mem_we !== we_o) begin
                    req_bad = 1'b1;
                end
                if (!granted && req_cnt == gnt_dly) begin
                    mem_bus.mem_gnt = 1'b1; granted = 1'b1; gnt_cyc = cyc;
                end
                req_cnt++;
            end else if (granted && !we && cyc == gnt_cyc + 1 + rv_dly) begin
                mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rword;
            end
        end
        @(posedge clk); #1;
        if (lsu_done !== 1'b0) extra_bad = 1'b1;
        lsu_valid = 1'b0; mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", lsu_done); end
        vectors++; if (lsu_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", lsu_err); end
        vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req got %b want 0", mem_bus.mem_req); end
        vectors++; if (mem_bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we got %b want 0", mem_bus.mem_we); end
        vectors++; if (mem_bus.mem_be !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_be got %b want 0000", mem_bus.mem_be); end
        vectors++; if (mem_bus.mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr got %h want 0", mem_bus.mem_addr); end
        vectors++; if (mem_bus.mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata got %h want 0", mem_bus.mem_wdata); end
        vectors++; if (lsu_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata got %h want 0", lsu_rdata); end
        rst_n = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_store;
        int dc; logic e, rs, rb, wo, xb; logic [31:0] rd, ao, wdo; logic [3:0] bo;
        applyStimulus(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 32'h0, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
        vectors++; if (bo !== 4'b1111) begin miscompares++; $display("[TB] FAIL sw_be got %b want 1111", bo); end
        vectors++; if (ao !== 32'h1000) begin miscompares++; $display("[TB] FAIL sw_addr got %h want 00001000", ao); end
        vectors++; if (wdo !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL sw_wdata got %h want deadbeef", wdo); end
        vectors++; if (wo !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_we got %b want 1", wo); end
        vectors++; if (dc != 2) begin miscompares++; $display("[TB] FAIL sw_done_cycle got %0d want 2", dc); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_err got %b want 0", e); end
        vectors++; if (rd !== exp_rdata) begin miscompares++; $display("[TB] FAIL sw_rdata_kept got %h want %h", rd, exp_rdata); end
        applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1, 0, 32'h0, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
        vectors++; if (bo !== 4'b1000) begin miscompares++; $display("[TB] FAIL sb_be got %b want 1000", bo); end
        vectors++; if (ao !== 32'h1000) begin miscompares++; $display("[TB] FAIL sb_addr got %h want 00001000", ao); end
        vectors++; if (wdo !== 32'hA5A5_A5A5) begin miscompares++; $display("[TB] FAIL sb_wdata got %h want a5a5a5a5", wdo); end
        vectors++; if (dc != 3) begin miscompares++; $display("[TB] FAIL sb_done_cycle got %0d want 3", dc); end
        vectors++; if (rb !== 1'b0 || xb !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_protocol got %b%b want 00", rb, xb); end
    endtask

    task automatic test_load_byte;
        int dc; logic e, rs, rb, wo, xb; logic [31:0] rd, ao, wdo; logic [3:0] bo;
        logic [31:0] want [2];
        logic [2:0]  f3s [2];
        want[0] = 32'hFFFF_FFF4; want[1] = 32'h0000_00F4;
        f3s[0] = 3'b000; f3s[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, f3s[i], 32'h0000_2002, 32'h0, 3, 2, 32'h12F4_5678, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
            exp_rdata = want[i];
            vectors++; if (rd !== want[i]) begin miscompares++; $display("[TB] FAIL lb_rdata[%0d] got %h want %h", i, rd, want[i]); end
            vectors++; if (dc != 8) begin miscompares++; $display("[TB] FAIL lb_done_cycle[%0d] got %0d want 8", i, dc); end
            vectors++; if (bo !== 4'b0100 || ao !== 32'h2000) begin miscompares++; $display("[TB] FAIL lb_bus[%0d] got be %b addr %h want 0100 00002000", i, bo, ao); end
            vectors++; if (rb !== 1'b0 || wo !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_req_stable[%0d] got bad %b we %b want 0 0", i, rb, wo); end
        end
    endtask

    task automatic test_misaligned;
        int dc; logic e, rs, rb, wo, xb; logic [31:0] rd, ao, wdo; logic [3:0] bo;
        logic [2:0]  f3s [2];
        logic [31:0] adr [2];
        f3s[0] = 3'b001; adr[0] = 32'h2001;
        f3s[1] = 3'b010; adr[1] = 32'h2002;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, f3s[i], adr[i], 32'h0, 0, 0, 32'h0, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
            vectors++; if (dc != 1) begin miscompares++; $display("[TB] FAIL misalign_done_cycle[%0d] got %0d want 1", i, dc); end
            vectors++; if (e !== 1'b1) begin miscompares++; $display("[TB] FAIL misalign_err[%0d] got %b want 1", i, e); end
            vectors++; if (rs !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_no_req[%0d] got %b want 0", i, rs); end
            vectors++; if (rd !== exp_rdata) begin miscompares++; $display("[TB] FAIL misalign_rdata[%0d] got %h want %h", i, rd, exp_rdata); end
        end
    endtask

    task automatic test_reset_mid;
        int dc; logic e, rs, rb, wo, xb; logic [31:0] rd, ao, wdo, word; logic [3:0] bo;
        // Variant 0 resets while the request is pending, variant 1 while awaiting rvalid.
        for (int v = 0; v < 2; v++) begin
            @(posedge clk); #1;
            lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h3000;
            @(posedge clk); #1;
            vectors++; if (mem_bus.mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_req_up[%0d] got %b want 1", v, mem_bus.mem_req); end
            mem_bus.mem_gnt = (v == 1);
            @(posedge clk); #1;
            mem_bus.mem_gnt = 1'b0;
            #3 rst_n = 1'b0;
            #1;
            vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_req_drop[%0d] got %b want 0", v, mem_bus.mem_req); end
            vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_done[%0d] got %b want 0", v, lsu_done); end
            lsu_valid = 1'b0;
            exp_rdata = 32'h0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        word = $urandom;
        applyStimulus(1'b0, 3'b010, 32'h0000_3004, 32'h0, 0, 0, word, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
        exp_rdata = word;
        vectors++; if (dc != 3) begin miscompares++; $display("[TB] FAIL post_reset_lw_cycle got %0d want 3", dc); end
        vectors++; if (rd !== word || e !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_lw got %h err %b want %h err 0", rd, e, word); end
    endtask

    task automatic test_random;
        int dc, gd, rvd, exp_dc; logic e, rs, rb, wo, xb, ok, we; logic [31:0] rd, ao, wdo, adr, wd, word; logic [3:0] bo;
        logic [2:0] f3;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
            adr = $urandom; wd = $urandom; word = $urandom;
            gd = $urandom_range(0, 3); rvd = $urandom_range(0, 3);
            applyStimulus(we, f3, adr, wd, gd, rvd, word, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
            ok = model_ok(we, f3, adr);
            exp_dc = !ok ? 1 : (we ? gd + 2 : gd + rvd + 3);
            if (ok && !we) exp_rdata = model_load(f3, adr, word);
            vectors++; if (dc != exp_dc) begin miscompares++; $display("[TB] FAIL rnd_done_cycle[%0d] got %0d want %0d", n, dc, exp_dc); end
            vectors++; if (e !== !ok) begin miscompares++; $display("[TB] FAIL rnd_err[%0d] got %b want %b", n, e, !ok); end
            vectors++; if (rd !== exp_rdata) begin miscompares++; $display("[TB] FAIL rnd_rdata[%0d] got %h want %h", n, rd, exp_rdata); end
            vectors++; if (rs !== ok || rb !== 1'b0 || xb !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_protocol[%0d] got req %b bad %b%b want %b 00", n, rs, rb, xb, ok); end
            if (ok) begin
                vectors++; if (bo !== model_be(f3, adr)) begin miscompares++; $display("[TB] FAIL rnd_be[%0d] got %b want %b", n, bo, model_be(f3, adr)); end
                vectors++; if (ao !== {adr[31:2], 2'b00}) begin miscompares++; $display("[TB] FAIL rnd_addr[%0d] got %h want %h", n, ao, {adr[31:2], 2'b00}); end
                vectors++; if (wo !== we) begin miscompares++; $display("[TB] FAIL rnd_we[%0d] got %b want %b", n, wo, we); end
                if (we) begin
                    vectors++; if (wdo !== model_wdata(f3, wd)) begin miscompares++; $display("[TB] FAIL rnd_wdata[%0d] got %h want %h", n, wdo, model_wdata(f3, wd)); end
                end
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout;
        int dc; logic e, rs, rb, wo, xb; logic [31:0] rd, ao, wdo; logic [3:0] bo;
        applyStimulus(1'b0, 3'b010, 32'h0000_4000, 32'h0, 1000, 0, 32'h0, dc, e, rd, rs, rb, bo, ao, wdo, wo, xb);
        vectors++; if (dc != 1 + TIMEOUT) begin miscompares++; $display("[TB] FAIL timeout_cycle got %0d want %0d", dc, 1 + TIMEOUT); end
        vectors++; if (e !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err got %b want 1", e); end
        vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_req got %b want 0", mem_bus.mem_req); end
    endtask
`endif

    initial begin
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = '0;
        test_reset();
        test_store();
        test_load_byte();
        test_misaligned();
        test_reset_mid();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
